pagerank_gather: RTL and testbench

//  Receiving end of the PageRank scatter stream: accepts (node_id, contribution) beats, accumulates them
//  per destination node of one graph partition, then applies damping and streams out the new rank of

---
 rtl/pagerank_gather.sv | 164 ++++++++++++++++
 tb/tb_pagerank_gather.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pagerank_gather.sv
// Purpose : PageRank gather stage. Accumulates (node_id, contribution) beats per local node,
//           then streams out BASE_RANK + d*acc for every node of the partition in index order.
// Latency : first out beat 1 cycle after entering APPLY, then 1 node/cycle while out_ready=1.
// Backpr. : in_ready only in ACCUM (1 beat/cycle); out stream holds outputs stable while out_ready=0.
//
// Ports:
//   clock, reset_n                 rising-edge clock, async active-low reset
//   gather_enable                  level; starts a pass from IDLE, must drop after DONE to re-arm
//   in_valid/in_ready              contribution beat handshake
//   in_node_id, in_contrib         global destination id, Q32.32 contribution
//   scatter_done                   no further beats for this pass
//   out_valid/out_ready            rank stream handshake
//   out_node_id, out_rank          global node id, new Q32.32 rank
//   err_bad_id                     1-cycle pulse after an accepted beat outside the partition
//   operation_complete             high while in DONE
module pagerank_gather #(
   parameter int unsigned NODES_IN_PARTITION = 4,
   parameter logic [31:0] NODE_BASE          = 32'd0,
   parameter logic [15:0] DAMPING_Q16        = 16'd55706,
   parameter logic [63:0] BASE_RANK          = 64'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        gather_enable,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_node_id,
   input  logic [63:0] in_contrib,
   input  logic        scatter_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_node_id,
   output logic [63:0] out_rank,
   output logic        err_bad_id,
   output logic        operation_complete
);

   localparam int unsigned IDX_W = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES_IN_PARTITION - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_APPLY,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [63:0]       acc_q [NODES_IN_PARTITION];
   logic [63:0]       acc_d [NODES_IN_PARTITION];
   logic [IDX_W-1:0]  index_q, index_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_node_id_q, out_node_id_d;
   logic [63:0]       out_rank_q, out_rank_d;
   logic              err_bad_id_q, err_bad_id_d;

   logic [31:0]       beat_off;
   logic              beat_in_range;
   logic [IDX_W-1:0]  beat_idx;
   logic [64:0]       acc_sum;
   logic [IDX_W-1:0]  index_nxt;

   // Ids below NODE_BASE wrap to huge offsets, so one unsigned compare covers both sides.
   assign beat_off      = in_node_id - NODE_BASE;
   assign beat_in_range = (beat_off < NODES_IN_PARTITION);
   assign beat_idx      = beat_off[IDX_W-1:0];
   // Each beat reads and writes the accumulator in the same cycle, so back-to-back beats
   // to one node always see the previous beat's result.
   assign acc_sum       = {1'b0, acc_q[beat_idx]} + {1'b0, in_contrib};
   assign index_nxt     = index_q + IDX_W'(1);

   // BASE_RANK + ((acc * d) >> 16), 80-bit product, sum saturated to 64 bits.
   function automatic logic [63:0] damp_rank(input logic [63:0] acc);
      logic [63:0] scaled;
      logic [64:0] sum;
      scaled = 64'(({16'd0, acc} * {64'd0, DAMPING_Q16}) >> 16);
      sum    = {1'b0, BASE_RANK} + {1'b0, scaled};
      return sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : sum[63:0];
   endfunction

   always_comb begin
      state_d       = state_q;
      acc_d         = acc_q;
      index_d       = index_q;
      out_valid_d   = out_valid_q;
      out_node_id_d = out_node_id_q;
      out_rank_d    = out_rank_q;
      err_bad_id_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gather_enable) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            for (int i = 0; i < int'(NODES_IN_PARTITION); i++) acc_d[i] = '0;
            index_d       = '0;
            out_valid_d   = 1'b0;
            out_node_id_d = '0;
            out_rank_d    = '0;
            state_d       = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (in_valid) begin
               if (beat_in_range) begin
                  acc_d[beat_idx] = acc_sum[64] ? 64'hFFFF_FFFF_FFFF_FFFF : acc_sum[63:0];
               end else begin
                  err_bad_id_d = 1'b1;
               end
            end
            if (scatter_done) state_d = ST_APPLY;
         end
         ST_APPLY: begin
            if (!out_valid_q) begin
               // First cycle in APPLY: present node 0.
               out_valid_d   = 1'b1;
               out_node_id_d = NODE_BASE + 32'(index_q);
               out_rank_d    = damp_rank(acc_q[index_q]);
            end else if (out_ready) begin
               if (index_q == LAST_IDX) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_DONE;
               end else begin
                  index_d       = index_nxt;
                  out_node_id_d = NODE_BASE + 32'(index_nxt);
                  out_rank_d    = damp_rank(acc_q[index_nxt]);
               end
            end
         end
         ST_DONE: begin
            if (!gather_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < int'(NODES_IN_PARTITION); i++) acc_q[i] <= '0;
         index_q       <= '0;
         out_valid_q   <= 1'b0;
         out_node_id_q <= '0;
         out_rank_q    <= '0;
         err_bad_id_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         acc_q         <= acc_d;
         index_q       <= index_d;
         out_valid_q   <= out_valid_d;
         out_node_id_q <= out_node_id_d;
         out_rank_q    <= out_rank_d;
         err_bad_id_q  <= err_bad_id_d;
      end
   end

   assign in_ready           = (state_q == ST_ACCUM);
   assign operation_complete = (state_q == ST_DONE);
   assign out_valid          = out_valid_q;
   assign out_node_id        = out_node_id_q;
   assign out_rank           = out_rank_q;
   assign err_bad_id         = err_bad_id_q;

endmodule

// File: tb/tb_pagerank_gather.sv
// Purpose : bench for pagerank_gather; two instances (base 0 / base 8 with nonzero BASE_RANK).
// Latency : passes driven and sampled on the falling edge.
// Backpr. : out_ready held high or toggled 1,0,0,1 during APPLY.
module tb_pagerank_gather;

   localparam logic [63:0] QH  = 64'h0000_0000_8000_0000;   // 0.5
   localparam logic [63:0] Q1  = 64'h0000_0001_0000_0000;
   localparam logic [63:0] Q2  = 64'h0000_0002_0000_0000;
   localparam logic [63:0] Q3  = 64'h0000_0003_0000_0000;
   localparam logic [63:0] Q4  = 64'h0000_0004_0000_0000;
   localparam logic [63:0] Q5  = 64'h0000_0005_0000_0000;
   localparam logic [63:0] Q15 = 64'h0000_0001_8000_0000;   // 1.5
   localparam logic [63:0] BIG = 64'hF000_0000_0000_0000;
   localparam logic [63:0] SAT = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] BB  = 64'h8000_0001_0000_0000;   // BASE_RANK of instance B

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ge_a = 1'b0, ge_b = 1'b0;
   logic        in_valid = 1'b0, scatter_done = 1'b0, out_ready = 1'b0;
   logic [31:0] in_node_id = '0;
   logic [63:0] in_contrib = '0;
   logic        sel = 1'b0;

   logic        a_in_ready, a_out_valid, a_err, a_done;
   logic [31:0] a_out_id;
   logic [63:0] a_out_rank;
   logic        b_in_ready, b_out_valid, b_err, b_done;
   logic [31:0] b_out_id;
   logic [63:0] b_out_rank;

   logic        m_in_rdy, m_out_vld, m_err, m_done;
   logic [31:0] m_id;
   logic [63:0] m_rank;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pagerank_gather #(.NODES_IN_PARTITION(4), .NODE_BASE(32'd0), .DAMPING_Q16(16'd32768),
                     .BASE_RANK(64'h0)) dut_a (
      .clock(clock), .reset_n(reset_n), .gather_enable(ge_a),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_node_id(in_node_id),
      .in_contrib(in_contrib), .scatter_done(scatter_done),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_node_id(a_out_id),
      .out_rank(a_out_rank), .err_bad_id(a_err), .operation_complete(a_done));

   pagerank_gather #(.NODES_IN_PARTITION(4), .NODE_BASE(32'd8), .DAMPING_Q16(16'd32768),
                     .BASE_RANK(BB)) dut_b (
      .clock(clock), .reset_n(reset_n), .gather_enable(ge_b),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_node_id(in_node_id),
      .in_contrib(in_contrib), .scatter_done(scatter_done),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_node_id(b_out_id),
      .out_rank(b_out_rank), .err_bad_id(b_err), .operation_complete(b_done));

   assign m_in_rdy  = sel ? b_in_ready  : a_in_ready;
   assign m_out_vld = sel ? b_out_valid : a_out_valid;
   assign m_err     = sel ? b_err       : a_err;
   assign m_done    = sel ? b_done      : a_done;
   assign m_id      = sel ? b_out_id    : a_out_id;
   assign m_rank    = sel ? b_out_rank  : a_out_rank;

   typedef struct {
      logic             sel;       // 0: instance A, 1: instance B
      int               nbeats;
      logic             dwl;       // scatter_done rides on the last beat
      logic [3:0][31:0] ids;
      logic [3:0][63:0] contribs;
      logic [3:0][63:0] exp_rank;
      int               exp_err;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mkv(input logic s, input int nb, input logic dwl,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] i2, input logic [31:0] i3,
                                input logic [63:0] c0, input logic [63:0] c1,
                                input logic [63:0] c2, input logic [63:0] c3,
                                input logic [63:0] r0, input logic [63:0] r1,
                                input logic [63:0] r2, input logic [63:0] r3, input int e);
      vec_t v;
      v.sel = s; v.nbeats = nb; v.dwl = dwl; v.exp_err = e;
      v.ids[0] = i0; v.ids[1] = i1; v.ids[2] = i2; v.ids[3] = i3;
      v.contribs[0] = c0; v.contribs[1] = c1; v.contribs[2] = c2; v.contribs[3] = c3;
      v.exp_rank[0] = r0; v.exp_rank[1] = r1; v.exp_rank[2] = r2; v.exp_rank[3] = r3;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called on a falling edge with the selected instance in IDLE; returns on a falling edge in IDLE.
   task automatic run_pass(input vec_t v, input string tag, input logic bp);
      int          k;
      int          errs;
      logic [3:0]  pat;
      logic        prev_stall;
      logic [31:0] prev_id;
      logic [63:0] prev_rank;
      logic [31:0] base_id;
      base_id = v.sel ? 32'd8 : 32'd0;
      pat = bp ? 4'b1001 : 4'b1111;
      sel = v.sel;
      if (v.sel) ge_b = 1'b1; else ge_a = 1'b1;
      @(negedge clock);
      chk({tag, " clear_in_ready"}, 64'(m_in_rdy), 64'd0);
      @(negedge clock);
      chk({tag, " accum_in_ready"}, 64'(m_in_rdy), 64'd1);
      errs = 0;
      for (int b = 0; b < v.nbeats; b++) begin
         in_valid     = 1'b1;
         in_node_id   = v.ids[b];
         in_contrib   = v.contribs[b];
         scatter_done = v.dwl && (b == v.nbeats - 1);
         @(negedge clock);
         if (m_err) errs++;
      end
      if (!(v.dwl && v.nbeats > 0)) begin
         in_valid     = 1'b0;
         scatter_done = 1'b1;
         @(negedge clock);
         if (m_err) errs++;
      end
      in_valid     = 1'b0;
      scatter_done = 1'b0;
      // First APPLY cycle: nothing presented yet, input side closed.
      chk({tag, " apply_first_valid"}, 64'(m_out_vld), 64'd0);
      chk({tag, " apply_in_ready"}, 64'(m_in_rdy), 64'd0);
      @(negedge clock);
      k = 0;
      prev_stall = 1'b0;
      prev_id = '0;
      prev_rank = '0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         out_ready = pat[c % 4];
         if (m_out_vld) begin
            if (prev_stall) begin
               chk($sformatf("%s stall_id", tag), 64'(m_id), 64'(prev_id));
               chk($sformatf("%s stall_rank", tag), m_rank, prev_rank);
            end
            if (out_ready) begin
               chk($sformatf("%s node%0d_id", tag, k), 64'(m_id), 64'(base_id + 32'(k)));
               chk($sformatf("%s node%0d_rank", tag, k), m_rank, v.exp_rank[k]);
               k++;
            end
         end
         prev_stall = m_out_vld && !out_ready;
         prev_id    = m_id;
         prev_rank  = m_rank;
         if (k < 4) @(negedge clock);
      end
      chk({tag, " emitted_count"}, 64'(k), 64'd4);
      @(negedge clock);
      out_ready = 1'b0;
      chk({tag, " done_complete"}, 64'(m_done), 64'd1);
      chk({tag, " done_valid"}, 64'(m_out_vld), 64'd0);
      if (m_err) errs++;
      chk({tag, " err_count"}, 64'(errs), 64'(v.exp_err));
      ge_a = 1'b0;
      ge_b = 1'b0;
      @(negedge clock);
      chk({tag, " idle_complete"}, 64'(m_done), 64'd0);
   endtask

   initial begin
      vec_t vr;
      // sel nb dwl | ids x4 | contribs x4 | expected ranks x4 | err pulses
      vecs[0] = mkv(0, 3, 0, 1, 1, 3, 0, Q2, Q2, Q1, 0, 0, Q2, 0, QH, 0);
      vecs[1] = mkv(0, 2, 1, 0, 2, 0, 0, Q1, Q4, 0, 0, QH, 0, Q2, 0, 0);
      vecs[2] = mkv(1, 2, 0, 3, 12, 0, 0, Q1, Q2, 0, 0, BB, BB, BB, BB, 2);
      vecs[3] = mkv(0, 2, 0, 0, 0, 0, 0, BIG, BIG, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 0);
      vecs[4] = mkv(1, 2, 1, 8, 8, 0, 0, BIG, BIG, 0, 0, SAT, BB, BB, BB, 0);
      vecs[5] = mkv(1, 3, 0, 9, 11, 9, 0, Q3, Q1, Q1, 0,
                    BB, 64'h8000_0003_0000_0000, BB, 64'h8000_0001_8000_0000, 0);
      vecs[6] = mkv(0, 2, 0, 4, 3, 0, 0, Q1, Q3, 0, 0, 0, 0, 0, Q15, 1);
      vecs[7] = mkv(0, 4, 0, 0, 1, 2, 3, Q1, Q2, Q3, Q4, QH, Q1, Q15, Q2, 0);

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_a_in_ready", 64'(a_in_ready), 64'd0);
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_out_rank", a_out_rank, 64'd0);
      chk("rst_b_complete", 64'(b_done), 64'd0);
      chk("rst_b_out_id", 64'(b_out_id), 64'd0);
      reset_n = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 7; i++) run_pass(vecs[i], $sformatf("vec%0d", i), 1'b0);

      // Backpressure: out_ready 1,0,0,1 through APPLY
      run_pass(vecs[7], "backpressure", 1'b1);

      // Reset mid-ACCUM with acc[1]=5.0 pending
      sel = 1'b0;
      ge_a = 1'b1;
      repeat (2) @(negedge clock);
      chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
      in_valid = 1'b1; in_node_id = 32'd1; in_contrib = Q5;
      @(negedge clock);
      in_valid = 1'b0;
      reset_n = 1'b0;
      ge_a = 1'b0;
      #1;
      chk("midrst_in_ready_low", 64'(a_in_ready), 64'd0);
      chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
      chk("midrst_err", 64'(a_err), 64'd0);
      chk("midrst_complete", 64'(a_done), 64'd0);
      chk("midrst_out_id", 64'(a_out_id), 64'd0);
      chk("midrst_out_rank", a_out_rank, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("postrst_idle", 64'(a_in_ready), 64'd0);
      vr = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_pass(vr, "postrst", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
